// File: rtl/window_3x3_gen.sv
// window_3x3_gen
//   Builds a sliding 3x3 pixel window from a raster-order 8-bit pixel stream.
//   Two line buffers hold the previous two rows. Only interior windows are
//   flagged valid, so border centres never produce a window.
//
// Parameters
//   IMG_W      pixels per row   (3..1023)
//   IMG_H      rows per frame   (3..1023)
//
// Ports
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   pix_in     raster-order pixel
//   pix_valid  pix_in is accepted on this rising edge
//   pix_sof    (WIN_SYNC_EN only) accepted pixel is forced to position (0,0)
//   p0..p8     window, row-major; p0 top-left, p4 centre, p8 newest pixel
//   win_valid  one-cycle strobe marking a new window on p0..p8/win_x/win_y
//   win_x      column of the centre pixel p4
//   win_y      row of the centre pixel p4
//   win_sof    (WIN_SYNC_EN only) set with win_valid for the window at (1,1)
//
// Configuration
//   WIN_SYNC_EN  adds pix_sof/win_sof frame synchronisation.
module window_3x3_gen #(
    parameter int IMG_W = 320,
    parameter int IMG_H = 240
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] pix_in,
    input  logic       pix_valid,
`ifdef WIN_SYNC_EN
    input  logic       pix_sof,
    output logic       win_sof,
`endif
    output logic [7:0] p0,
    output logic [7:0] p1,
    output logic [7:0] p2,
    output logic [7:0] p3,
    output logic [7:0] p4,
    output logic [7:0] p5,
    output logic [7:0] p6,
    output logic [7:0] p7,
    output logic [7:0] p8,
    output logic       win_valid,
    output logic [9:0] win_x,
    output logic [9:0] win_y
);

    localparam int AW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam logic [9:0] LAST_X = 10'(IMG_W - 1);
    localparam logic [9:0] LAST_Y = 10'(IMG_H - 1);

    logic [9:0]    x_q, y_q, x_d, y_d;
    logic [9:0]    cur_x, cur_y;
    logic          frame_start;
    logic          win_trig;
    logic [AW-1:0] col;
    logic [7:0]    lb0_rd, lb1_rd;

    // Line buffers are intentionally not reset: rows 0 and 1 of every frame
    // overwrite them before any window using them can be flagged valid.
    logic [7:0] lb0 [IMG_W];
    logic [7:0] lb1 [IMG_W];

    logic [7:0] win_q [9];
    logic       win_valid_q;
    logic [9:0] win_x_q, win_y_q;
    logic       win_sof_q;

`ifdef WIN_SYNC_EN
    assign frame_start = pix_sof;
`else
    assign frame_start = 1'b0;
`endif

    // Position of the pixel being accepted; start-of-frame overrides counters.
    always_comb begin
        cur_x = frame_start ? 10'd0 : x_q;
        cur_y = frame_start ? 10'd0 : y_q;
    end

    assign col      = cur_x[AW-1:0];
    assign lb0_rd   = lb0[col];
    assign lb1_rd   = lb1[col];
    assign win_trig = pix_valid && (cur_x >= 10'd2) && (cur_y >= 10'd2);

    always_comb begin
        x_d = x_q;
        y_d = y_q;
        if (pix_valid) begin
            if (cur_x == LAST_X) begin
                x_d = 10'd0;
                y_d = (cur_y == LAST_Y) ? 10'd0 : cur_y + 10'd1;
            end else begin
                x_d = cur_x + 10'd1;
                y_d = cur_y;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (pix_valid) begin
            lb0[col] <= lb1_rd;
            lb1[col] <= pix_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q         <= 10'd0;
            y_q         <= 10'd0;
            win_valid_q <= 1'b0;
            win_x_q     <= 10'd0;
            win_y_q     <= 10'd0;
            win_sof_q   <= 1'b0;
            for (int i = 0; i < 9; i++) begin
                win_q[i] <= 8'd0;
            end
        end else begin
            x_q         <= x_d;
            y_q         <= y_d;
            win_valid_q <= win_trig;
            win_sof_q   <= win_trig && (cur_x == 10'd2) && (cur_y == 10'd2);
            if (win_trig) begin
                win_x_q <= cur_x - 10'd1;
                win_y_q <= cur_y - 10'd1;
            end
            if (pix_valid) begin
                // Columns shift left; new column {row y-2, row y-1, row y} enters right.
                win_q[0] <= win_q[1];
                win_q[1] <= win_q[2];
                win_q[2] <= lb0_rd;
                win_q[3] <= win_q[4];
                win_q[4] <= win_q[5];
                win_q[5] <= lb1_rd;
                win_q[6] <= win_q[7];
                win_q[7] <= win_q[8];
                win_q[8] <= pix_in;
            end
        end
    end

    assign p0        = win_q[0];
    assign p1        = win_q[1];
    assign p2        = win_q[2];
    assign p3        = win_q[3];
    assign p4        = win_q[4];
    assign p5        = win_q[5];
    assign p6        = win_q[6];
    assign p7        = win_q[7];
    assign p8        = win_q[8];
    assign win_valid = win_valid_q;
    assign win_x     = win_x_q;
    assign win_y     = win_y_q;

`ifdef WIN_SYNC_EN
    assign win_sof = win_sof_q;
`else
    logic unused_sof;
    assign unused_sof = win_sof_q;
`endif

endmodule

// File: tb/tb_window_3x3_gen.sv
// Self-checking bench for window_3x3_gen at IMG_W=5, IMG_H=4.
// Windows expected from a reference frame model are queued as pixels are
// driven and compared in order as win_valid strobes appear.
module tb_window_3x3_gen;

    localparam int W = 5;
    localparam int H = 4;

    typedef struct packed {
        logic [8:0][7:0] p;
        logic [9:0]      x;
        logic [9:0]      y;
        logic            sof;
    } win_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] pix_in = 8'd0;
    logic       pix_valid = 1'b0;
    logic [7:0] p0, p1, p2, p3, p4, p5, p6, p7, p8;
    logic       win_valid;
    logic [9:0] win_x, win_y;
`ifdef WIN_SYNC_EN
    logic       pix_sof = 1'b0;
    logic       win_sof;
`endif

    logic [8:0][7:0] obs;
    assign obs = {p8, p7, p6, p5, p4, p3, p2, p1, p0};

    int   errors = 0;
    int   checks = 0;
    win_t sb[$];
    win_t e;
    logic [7:0] frame [H][W];
    int   mx = 0;
    int   my = 0;
    int   nwin;
    int   npix;
    bit   prev_valid;

    window_3x3_gen #(.IMG_W(W), .IMG_H(H)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .pix_in    (pix_in),
        .pix_valid (pix_valid),
`ifdef WIN_SYNC_EN
        .pix_sof   (pix_sof),
        .win_sof   (win_sof),
`endif
        .p0        (p0),
        .p1        (p1),
        .p2        (p2),
        .p3        (p3),
        .p4        (p4),
        .p5        (p5),
        .p6        (p6),
        .p7        (p7),
        .p8        (p8),
        .win_valid (win_valid),
        .win_x     (win_x),
        .win_y     (win_y)
    );

    always #5 clk = ~clk;

    // Drive one cycle; on acceptance update the frame model and queue any window.
    task automatic send(input int v, input bit valid, input bit sof);
        win_t w;
        pix_in    = 8'(v);
        pix_valid = valid;
`ifdef WIN_SYNC_EN
        pix_sof   = sof;
`endif
        if (valid) begin
            if (sof) begin
                mx = 0;
                my = 0;
            end
            frame[my][mx] = 8'(v);
            if (mx >= 2 && my >= 2) begin
                for (int r = 0; r < 3; r++)
                    for (int c = 0; c < 3; c++)
                        w.p[r*3+c] = frame[my-2+r][mx-2+c];
                w.x   = 10'(mx - 1);
                w.y   = 10'(my - 1);
                w.sof = (mx == 2 && my == 2);
                sb.push_back(w);
            end
            if (mx == W - 1) begin
                mx = 0;
                my = (my == H - 1) ? 0 : my + 1;
            end else begin
                mx = mx + 1;
            end
            npix++;
        end
        @(posedge clk);
        #1;
        pix_valid = 1'b0;
`ifdef WIN_SYNC_EN
        pix_sof   = 1'b0;
`endif
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if (win_valid !== 1'b0 || win_x !== 10'd0 || win_y !== 10'd0) begin
            errors++;
            $display("FAIL reset_ctrl: valid=%b x=%0d y=%0d required 0 0 0", win_valid, win_x, win_y);
        end
        checks++;
        if (obs !== '0) begin
            errors++;
            $display("FAIL reset_window: got %h required 0", obs);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_stream();
        logic [8:0][7:0] first_exp, last_exp;
        first_exp = {8'd13, 8'd12, 8'd11, 8'd8, 8'd7, 8'd6, 8'd3, 8'd2, 8'd1};
        last_exp  = {8'd20, 8'd19, 8'd18, 8'd15, 8'd14, 8'd13, 8'd10, 8'd9, 8'd8};
        nwin = 0;
        npix = 0;
        for (int i = 1; i <= 20; i++) begin
            send(i, 1'b1, 1'b0);
            if (win_valid) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL stream_extra: unexpected window at x=%0d y=%0d", win_x, win_y);
                end else begin
                    e = sb.pop_front();
                    if (obs !== e.p || win_x !== e.x || win_y !== e.y) begin
                        errors++;
                        $display("FAIL stream_win%0d: got %h x=%0d y=%0d required %h x=%0d y=%0d",
                                 nwin, obs, win_x, win_y, e.p, e.x, e.y);
                    end
                end
                if (nwin == 0) begin
                    checks++;
                    if (obs !== first_exp || win_x !== 10'd1 || win_y !== 10'd1 || npix != 13) begin
                        errors++;
                        $display("FAIL stream_first: got %h x=%0d y=%0d after pixel %0d required %h 1 1 13",
                                 obs, win_x, win_y, npix, first_exp);
                    end
                end
                if (nwin == 5) begin
                    checks++;
                    if (obs !== last_exp || win_x !== 10'd3 || win_y !== 10'd2) begin
                        errors++;
                        $display("FAIL stream_last: got %h x=%0d y=%0d required %h 3 2",
                                 obs, win_x, win_y, last_exp);
                    end
                end
                nwin++;
            end
        end
        send(0, 1'b0, 1'b0);
        checks++;
        if (win_valid !== 1'b0 || obs !== last_exp) begin
            errors++;
            $display("FAIL stream_hold: valid=%b win=%h required 0 %h", win_valid, obs, last_exp);
        end
        checks++;
        if (nwin != 6 || sb.size() != 0) begin
            errors++;
            $display("FAIL stream_count: got %0d windows, %0d pending required 6, 0", nwin, sb.size());
        end
    endtask

    task automatic test_gaps();
        nwin = 0;
        prev_valid = 1'b0;
        for (int i = 1; i <= 40; i++) begin
            if (i % 2) send((i + 1) / 2, 1'b1, 1'b0);
            else       send(0, 1'b0, 1'b0);
            if (win_valid && prev_valid) begin
                checks++;
                errors++;
                $display("FAIL gaps_consecutive: win_valid high two cycles at step %0d required single", i);
            end
            prev_valid = win_valid;
            if (win_valid) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL gaps_extra: unexpected window at x=%0d y=%0d", win_x, win_y);
                end else begin
                    e = sb.pop_front();
                    if (obs !== e.p || win_x !== e.x || win_y !== e.y) begin
                        errors++;
                        $display("FAIL gaps_win%0d: got %h x=%0d y=%0d required %h x=%0d y=%0d",
                                 nwin, obs, win_x, win_y, e.p, e.x, e.y);
                    end
                end
                nwin++;
            end
        end
        checks++;
        if (nwin != 6 || sb.size() != 0) begin
            errors++;
            $display("FAIL gaps_count: got %0d windows, %0d pending required 6, 0", nwin, sb.size());
        end
    endtask

    task automatic test_back_to_back();
        logic [8:0][7:0] w7_exp;
        w7_exp = {8'd33, 8'd32, 8'd31, 8'd28, 8'd27, 8'd26, 8'd23, 8'd22, 8'd21};
        nwin = 0;
        for (int i = 1; i <= 40; i++) begin
            send(i, 1'b1, 1'b0);
            if (win_valid) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL b2b_extra: unexpected window at x=%0d y=%0d", win_x, win_y);
                end else begin
                    e = sb.pop_front();
                    if (obs !== e.p || win_x !== e.x || win_y !== e.y) begin
                        errors++;
                        $display("FAIL b2b_win%0d: got %h x=%0d y=%0d required %h x=%0d y=%0d",
                                 nwin, obs, win_x, win_y, e.p, e.x, e.y);
                    end
                end
                if (nwin == 6) begin
                    checks++;
                    if (obs !== w7_exp || win_x !== 10'd1 || win_y !== 10'd1) begin
                        errors++;
                        $display("FAIL b2b_win7: got %h x=%0d y=%0d required %h 1 1",
                                 obs, win_x, win_y, w7_exp);
                    end
                end
                nwin++;
            end
        end
        checks++;
        if (nwin != 12 || sb.size() != 0) begin
            errors++;
            $display("FAIL b2b_count: got %0d windows, %0d pending required 12, 0", nwin, sb.size());
        end
    endtask

    task automatic test_reset_midframe();
        for (int i = 1; i <= 7; i++) send(i + 100, 1'b1, 1'b0);
        #3;
        rst_n = 1'b0;
        #1;
        checks++;
        if (win_valid !== 1'b0 || win_x !== 10'd0 || win_y !== 10'd0 || obs !== '0) begin
            errors++;
            $display("FAIL midreset_outputs: valid=%b x=%0d y=%0d win=%h required all 0",
                     win_valid, win_x, win_y, obs);
        end
        sb.delete();
        mx = 0;
        my = 0;
        @(negedge clk);
        rst_n = 1'b1;
        test_stream();
    endtask

`ifdef WIN_SYNC_EN
    task automatic test_sof();
        for (int i = 1; i <= 8; i++) send(i + 200, 1'b1, 1'b0);
        sb.delete();
        nwin = 0;
        for (int i = 1; i <= 20; i++) begin
            send(i, 1'b1, i == 1);
            if (win_valid) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL sof_extra: unexpected window at x=%0d y=%0d", win_x, win_y);
                end else begin
                    e = sb.pop_front();
                    if (obs !== e.p || win_x !== e.x || win_y !== e.y || win_sof !== e.sof) begin
                        errors++;
                        $display("FAIL sof_win%0d: got %h x=%0d y=%0d sof=%b required %h x=%0d y=%0d sof=%b",
                                 nwin, obs, win_x, win_y, win_sof, e.p, e.x, e.y, e.sof);
                    end
                end
                nwin++;
            end else begin
                checks++;
                if (win_sof !== 1'b0) begin
                    errors++;
                    $display("FAIL sof_idle: win_sof=%b without win_valid required 0", win_sof);
                end
            end
        end
        checks++;
        if (nwin != 6 || sb.size() != 0) begin
            errors++;
            $display("FAIL sof_count: got %0d windows, %0d pending required 6, 0", nwin, sb.size());
        end
    endtask
`endif

    initial begin
        test_reset();
        test_stream();
        test_gaps();
        test_back_to_back();
        test_reset_midframe();
`ifdef WIN_SYNC_EN
        test_sof();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/window_3x3_gen.md
WINDOW_3X3_GEN -- requirements
Module: window_3x3_gen

Interface
REQ-001 SHALL have parameter IMG_W, default 320, pixels per image row (3..1023).
REQ-002 SHALL have parameter IMG_H, default 240, rows per frame (3..1023).
REQ-003 SHALL have port clk  input  1  single system clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset; asynchronous, active-low.
REQ-005 SHALL have port pix_in  input  8  raster-order pixel (left to right, top to bottom).
REQ-006 SHALL have port pix_valid  input  1  pix_in accepted on any rising edge where it is 1.
REQ-007 SHALL have ports p0..p8  output  8 each  3x3 window, row-major; p0 top-left, p4 centre, p8 bottom-right (newest pixel).
REQ-008 SHALL have port win_valid  output  1  p0..p8, win_x and win_y hold a new window for exactly this cycle.
REQ-009 SHALL have port win_x  output  10  column of centre pixel p4.
REQ-010 SHALL have port win_y  output  10  row of centre pixel p4.

Function
REQ-011 SHALL keep column counter x (0..IMG_W-1) and row counter y (0..IMG_H-1) giving the position of the next accepted pixel.
REQ-012 On acceptance x SHALL increment; at IMG_W-1, x wraps to 0 and y increments; at (IMG_W-1, IMG_H-1) both wrap to 0 (next frame).
REQ-013 SHALL hold two line buffers of IMG_W x 8 bits, LB1 holding row y-1 and LB0 holding row y-2.
REQ-014 On acceptance at column x: LB0[x] <= old LB1[x], LB1[x] <= pix_in; the column {LB0[x], LB1[x], pix_in} shifts into the right column of the window, other columns shift left.
REQ-015 Window registers p0..p8 SHALL update only on acceptance; they hold their value otherwise.
REQ-016 win_valid SHALL be 1 in the cycle after accepting a pixel with y>=2 and x>=2, else 0.
REQ-017 win_x/win_y SHALL equal x-1/y-1 of the triggering pixel, registered with win_valid.
REQ-018 Latency SHALL be exactly one clock from the accepting edge to win_valid.
REQ-019 Only interior windows are emitted: (IMG_W-2)*(IMG_H-2) per frame; border centres produce none.
REQ-020 No backpressure: every pixel accepted; downstream median stage SHALL consume each window the cycle it is valid.
REQ-021 pix_valid gaps of any length SHALL NOT alter window content or count.
REQ-022 Window content spanning a row wrap (x<2) SHALL never be flagged valid.

Reset
REQ-023 rst_n low SHALL immediately force x=0, y=0, p0..p8=0, win_x=0, win_y=0, win_valid=0.
REQ-024 Line buffer contents SHALL NOT be reset; stale data is never flagged valid because rows 0 and 1 refill them first.
REQ-025 Reset mid-frame SHALL discard the partial frame; first pixel after release is (0,0).

Configuration
REQ-026 Macro WIN_SYNC_EN SHALL, when defined, add input pix_sof (1 bit) and output win_sof (1 bit).
REQ-027 With WIN_SYNC_EN: accepted pixel with pix_sof=1 is treated as (0,0) regardless of counters; partial frame discarded.
REQ-028 With WIN_SYNC_EN: win_sof=1 alongside win_valid for the window centred (1,1), else 0; reset value 0.
REQ-029 Without WIN_SYNC_EN: ports pix_sof/win_sof absent; counters free-run and resynchronise only by reset.

Verification (IMG_W=5, IMG_H=4, pixel value = y*5+x+1)
REQ-030 Stream 1..20 continuously -> 6 windows; first one cycle after pixel 13: p0..p8=1,2,3,6,7,8,11,12,13, win_x=1, win_y=1; last: 8,9,10,13,14,15,18,19,20, win_x=3, win_y=2.
REQ-031 Same stream, pix_valid alternating 1/0 -> identical 6 windows, win_valid never on two consecutive cycles.
REQ-032 Two frames back-to-back, values 1..40 -> 12 windows; window 7 = 21,22,23,26,27,28,31,32,33, win_x=1, win_y=1.
REQ-033 Send 7 pixels, pulse rst_n low mid-cycle -> outputs 0 immediately; resend 1..20 -> exactly REQ-030 result.
REQ-034 WIN_SYNC_EN: send 8 pixels, then 1..20 with pix_sof on pixel 1 -> 6 windows as REQ-030, win_sof=1 only on the first.
